// File: rtl/canny_pkg.sv
// Shared types for the Canny edge pipeline: gradient word layout, direction codes, NMS states.
package canny_pkg;

  localparam int unsigned MAG_W  = 8;
  localparam int unsigned DIR_W  = 2;
  localparam int unsigned GRAD_W = MAG_W + DIR_W;

  typedef enum logic [DIR_W-1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } dir_e;

  typedef struct packed {
    dir_e             dir;
    logic [MAG_W-1:0] mag;
  } grad_t;

  typedef enum logic [1:0] {
    PROLOGUE = 2'd0,
    SUPPRESS = 2'd1,
    DONE     = 2'd2
  } nms_state_e;

  // Centre survives only if it is no smaller than both neighbours along the gradient.
  function automatic logic [MAG_W-1:0] nms_keep(input logic [MAG_W-1:0] centre,
                                                input logic [MAG_W-1:0] nb_a,
                                                input logic [MAG_W-1:0] nb_b);
    return (centre >= nb_a && centre >= nb_b) ? centre : '0;
  endfunction

endpackage

// File: rtl/window_shift_reg.sv
// Line-buffer shift register holding two image rows plus three words; every entry is tapped.
module window_shift_reg
  import canny_pkg::*;
#(
  parameter int unsigned DEPTH = 19
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  input  grad_t                   din,
  output grad_t [DEPTH-1:0]       taps
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      taps <= '0;
    end else if (clear) begin
      taps <= '0;
    end else if (enable) begin
      taps <= {din, taps[DEPTH-1:1]};
    end
  end

endmodule

// File: rtl/non_maximum_suppression.sv
// Non-maximum suppression over a 3x3 gradient window, streaming FWFT FIFO in to FIFO out.
module non_maximum_suppression
  import canny_pkg::*;
#(
  parameter int unsigned WIDTH  = 1280,
  parameter int unsigned HEIGHT = 720
) (
  input  logic              clock,
  input  logic              reset,
  output logic              in_rd_en,
  input  logic              in_empty,
  input  logic [GRAD_W-1:0] in_dout,
  output logic              out_wr_en,
  input  logic              out_full,
  output logic [MAG_W-1:0]  out_din,
  output logic              frame_done
);

  localparam int unsigned DEPTH    = 2 * WIDTH + 3;
  localparam int unsigned NPIX     = WIDTH * HEIGHT;
  localparam int unsigned FLUSH_AT = NPIX - WIDTH - 3;
  localparam int unsigned PRO_POPS = WIDTH + 2;
  localparam int unsigned CNT_W    = $clog2(NPIX + 1);
  localparam int unsigned ROW_W    = $clog2(HEIGHT + 1);
  localparam int unsigned COL_W    = $clog2(WIDTH + 1);
  localparam int unsigned POP_W    = $clog2(PRO_POPS + 1);

  nms_state_e           state, state_next;
  logic [POP_W-1:0]     pop_cnt;
  logic [CNT_W-1:0]     pix_idx;
  logic [ROW_W-1:0]     row;
  logic [COL_W-1:0]     col;

  grad_t [DEPTH-1:0]    taps;
  grad_t                centre;
  grad_t                shift_din;
  logic [MAG_W-1:0]     nb_a, nb_b, pix_mag;
  logic                 flushing, pro_pop, advance, shift_en, border, last_pix;

  window_shift_reg #(.DEPTH(DEPTH)) u_window (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == DONE),
    .enable (shift_en),
    .din    (shift_din),
    .taps   (taps)
  );

  // Handshake: once the last real pixel has been popped, zeros are shifted in to drain the window.
  always_comb begin
    flushing  = pix_idx > CNT_W'(FLUSH_AT);
    pro_pop   = (state == PROLOGUE) && !in_empty;
    advance   = (state == SUPPRESS) && !out_full && (!in_empty || flushing);
    shift_en  = pro_pop || advance;
    shift_din = (advance && flushing) ? '0 : grad_t'(in_dout);
    border    = (row == '0) || (row == ROW_W'(HEIGHT - 1)) ||
                (col == '0) || (col == COL_W'(WIDTH - 1));
    last_pix  = (row == ROW_W'(HEIGHT - 1)) && (col == COL_W'(WIDTH - 1));
  end

  // Neighbour pair along the gradient direction of the centre pixel.
  always_comb begin
    centre = taps[WIDTH+1];
    nb_a   = '0;
    nb_b   = '0;
    case (centre.dir)
      DIR_0:   begin nb_a = taps[WIDTH].mag; nb_b = taps[WIDTH+2].mag;   end
      DIR_45:  begin nb_a = taps[2].mag;     nb_b = taps[2*WIDTH].mag;   end
      DIR_90:  begin nb_a = taps[1].mag;     nb_b = taps[2*WIDTH+1].mag; end
      default: begin nb_a = taps[0].mag;     nb_b = taps[2*WIDTH+2].mag; end
    endcase
    pix_mag = border ? '0 : nms_keep(centre.mag, nb_a, nb_b);
  end

  // Reset gates the pop request directly so nothing is consumed while held in reset.
  assign in_rd_en   = reset && (pro_pop || (advance && !flushing));
  assign out_wr_en  = advance;
  assign out_din    = advance ? pix_mag : '0;
  assign frame_done = (state == DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= PROLOGUE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PROLOGUE: if (pro_pop && pop_cnt == POP_W'(PRO_POPS - 1)) state_next = SUPPRESS;
      SUPPRESS: if (advance && last_pix) state_next = DONE;
      DONE:     state_next = PROLOGUE;
      default:  state_next = PROLOGUE;
    endcase
  end

  // Prologue pop count and raster position of the next output pixel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pop_cnt <= '0;
      pix_idx <= '0;
      row     <= '0;
      col     <= '0;
    end else if (state == DONE) begin
      pop_cnt <= '0;
      pix_idx <= '0;
      row     <= '0;
      col     <= '0;
    end else begin
      if (pro_pop) pop_cnt <= pop_cnt + 1'b1;
      if (advance) begin
        pix_idx <= pix_idx + 1'b1;
        if (col == COL_W'(WIDTH - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_non_maximum_suppression.sv
// Directed bench for non_maximum_suppression on an 8x6 image with a FWFT source model.
module tb_non_maximum_suppression;

  localparam int unsigned W    = 8;
  localparam int unsigned H    = 6;
  localparam int unsigned NPIX = W * H;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_rd_en;
  logic       in_empty;
  logic [9:0] in_dout;
  logic       out_wr_en;
  logic       out_full;
  logic [7:0] out_din;
  logic       frame_done;

  always #5 clock = ~clock;

  non_maximum_suppression #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_rd_en   (in_rd_en),
    .in_empty   (in_empty),
    .in_dout    (in_dout),
    .out_wr_en  (out_wr_en),
    .out_full   (out_full),
    .out_din    (out_din),
    .frame_done (frame_done)
  );

  logic [9:0] img  [NPIX];
  logic [7:0] expv [NPIX];
  logic [7:0] got  [NPIX];

  int checks = 0;
  int errors = 0;
  int rd_ptr, wr_cnt, fd_cnt, rd_empty_cnt, stall_act, idle_nz, frame_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mag_at(input int r, input int c);
    logic [9:0] w;
    w = img[r*W + c];
    return w[7:0];
  endfunction

  // Reference model computed directly from the 2-D image.
  task automatic build_expected();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        logic [9:0] w;
        logic [7:0] a, b, m;
        w = img[r*W + c];
        m = w[7:0];
        a = 8'h00;
        b = 8'h00;
        if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
          expv[r*W + c] = 8'h00;
        end else begin
          case (w[9:8])
            2'd0: begin a = mag_at(r, c-1);   b = mag_at(r, c+1);   end
            2'd1: begin a = mag_at(r-1, c+1); b = mag_at(r+1, c-1); end
            2'd2: begin a = mag_at(r-1, c);   b = mag_at(r+1, c);   end
            default: begin a = mag_at(r-1, c-1); b = mag_at(r+1, c+1); end
          endcase
          expv[r*W + c] = (m >= a && m >= b) ? m : 8'h00;
        end
      end
    end
  endtask

  task automatic set_image(input int kind);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0: img[i] = {2'd0, 8'h20};
        3: img[i] = {2'd0, 8'((i % W) * 16)};
        4: img[i] = {2'((i * 5 + i / 3) % 4), 8'((i * 37 + 11) & 255)};
        default: img[i] = 10'h000;
      endcase
    end
    if (kind == 1) begin
      img[2*W + 3] = {2'd2, 8'h40};
      img[1*W + 3] = {2'd0, 8'h50};
    end
    if (kind == 2) begin
      img[2*W + 3] = {2'd2, 8'h40};
      img[1*W + 3] = {2'd0, 8'h30};
      img[3*W + 3] = {2'd0, 8'h40};
    end
    build_expected();
  endtask

  // One clock: drive at posedge+1, sample at negedge, FIFO pointer follows sampled pop.
  task automatic cyc(input logic e, input logic f);
    logic s_rd, s_wr, s_fd;
    logic [7:0] s_dout;
    in_empty = e || (rd_ptr >= NPIX);
    out_full = f;
    in_dout  = (rd_ptr < NPIX) ? img[rd_ptr] : 10'h000;
    @(negedge clock);
    s_rd = in_rd_en; s_wr = out_wr_en; s_dout = out_din; s_fd = frame_done;
    if (s_rd && in_empty) rd_empty_cnt++;
    if (f && (s_rd || s_wr)) stall_act++;
    if (!s_wr && s_dout !== 8'h00) idle_nz++;
    if (s_wr) begin
      if (wr_cnt < NPIX) got[wr_cnt] = s_dout;
      wr_cnt++;
    end
    if (s_fd) fd_cnt++;
    if (s_rd) rd_ptr++;
    @(posedge clock);
    #1;
  endtask

  // mode 0 plain, 1 five-cycle output stall mid-row, 2 input empty every other cycle.
  task automatic run_frame(input int mode, input int abort_at);
    int n, hold, post;
    bit stalled_once;
    logic e, f;
    rd_ptr = 0; wr_cnt = 0; fd_cnt = 0; rd_empty_cnt = 0; stall_act = 0; idle_nz = 0;
    n = 0; hold = 0; post = 0; stalled_once = 1'b0;
    for (int i = 0; i < NPIX; i++) got[i] = 8'hxx;
    while (n < 1000 && post < 4 && !(abort_at > 0 && wr_cnt >= abort_at)) begin
      e = 1'b0;
      f = 1'b0;
      if (mode == 1 && wr_cnt == 19 && !stalled_once) begin
        hold = 5;
        stalled_once = 1'b1;
      end
      if (hold > 0) begin
        f = 1'b1;
        hold--;
      end
      if (mode == 2) e = (n % 2 == 1);
      cyc(e, f);
      if (fd_cnt > 0) post++;
      n++;
    end
    frame_cycles = n;
  endtask

  task automatic check_frame(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < NPIX; i++) if (got[i] !== expv[i]) mism++;
    check({tag, "_no_timeout"}, frame_cycles < 1000, 1);
    check({tag, "_writes"}, wr_cnt, NPIX);
    check({tag, "_pops"}, rd_ptr, NPIX);
    check({tag, "_frame_done"}, fd_cnt, 1);
    check({tag, "_rd_while_empty"}, rd_empty_cnt, 0);
    check({tag, "_din_when_idle"}, idle_nz, 0);
    check({tag, "_pixel_mismatches"}, mism, 0);
  endtask

  initial begin
    int n20, nz, sum;
    reset    = 1'b0;
    in_empty = 1'b0;
    out_full = 1'b0;
    in_dout  = 10'h155;
    rd_ptr   = 0;
    #12;
    check("reset_rd_en", in_rd_en, 0);
    check("reset_wr_en", out_wr_en, 0);
    check("reset_din", out_din, 0);
    check("reset_frame_done", frame_done, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    set_image(0);
    run_frame(0, 0);
    check_frame("flat");
    n20 = 0; nz = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (got[i] === 8'h20) n20++;
      if (got[i] === 8'h00) nz++;
    end
    check("flat_interior_count", n20, 24);
    check("flat_border_count", nz, 24);
    check("flat_pix_1_1", got[1*W + 1], 8'h20);
    check("flat_pix_0_0", got[0], 8'h00);
    check("flat_pix_5_7", got[NPIX-1], 8'h00);

    set_image(1);
    run_frame(0, 0);
    check_frame("single_n_larger");
    check("single_centre_suppressed", got[2*W + 3], 8'h00);
    check("single_north_kept", got[1*W + 3], 8'h50);

    set_image(2);
    run_frame(0, 0);
    check_frame("single_tie");
    check("single_centre_tie_kept", got[2*W + 3], 8'h40);

    set_image(3);
    run_frame(0, 0);
    check_frame("ramp");
    sum = 0;
    for (int i = 0; i < NPIX; i++) sum += int'(got[i]);
    check("ramp_all_zero", sum, 0);

    set_image(4);
    run_frame(0, 0);
    check_frame("pattern");

    run_frame(1, 0);
    check_frame("stall");
    check("stall_no_activity", stall_act, 0);

    run_frame(2, 0);
    check_frame("empty_toggle");

    run_frame(0, 20);
    check("abort_writes", wr_cnt, 20);
    reset    = 1'b0;
    in_empty = 1'b0;
    out_full = 1'b0;
    @(negedge clock);
    check("midreset_rd_en", in_rd_en, 0);
    check("midreset_wr_en", out_wr_en, 0);
    check("midreset_din", out_din, 0);
    check("midreset_frame_done", frame_done, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    run_frame(0, 0);
    check_frame("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
